// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU pipeline definitions: reset PC, NOP encoding, stage state
// encoding and per-stage payload widths.
package cpu_pipe_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   localparam int IF_ID_W  = 32;
   localparam int ID_EX_W  = 96;
   localparam int EX_MEM_W = 72;
   localparam int MEM_WB_W = 40;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FULL    = 2'd1,
      SKIDDED = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle between two pipeline stages; the slave
// modport is the stage register, the master modport drives it.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 16
) ();

   logic              i_valid;
   logic              o_ready;
   logic [PC_W-1:0]   i_pc;
   logic [DATA_W-1:0] i_data;
   logic              flush;
   logic              o_valid;
   logic              i_ready;
   logic [PC_W-1:0]   o_pc;
   logic [DATA_W-1:0] o_data;
   logic [CNT_W-1:0]  o_stall_cnt;

   modport slave (
      input  i_valid, i_pc, i_data, flush, i_ready,
      output o_ready, o_valid, o_pc, o_data, o_stall_cnt
   );

   modport master (
      output i_valid, i_pc, i_data, flush, i_ready,
      input  o_ready, o_valid, o_pc, o_data, o_stall_cnt
   );

endinterface

// File: rtl/pipe_stage_reg_skid.sv
// Two-entry skid buffer: main PC/data register, skid register and the
// EMPTY/FULL/SKIDDED state machine with a registered ready.
module pipe_skid_buf
   import cpu_pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEFAULT),
   parameter logic [DATA_W-1:0] NOP_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              i_valid,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   output logic              o_ready,
   output logic              o_valid,
   output logic [PC_W-1:0]   o_pc,
   output logic [DATA_W-1:0] o_data
);

   pipe_state_t       r_state;
   logic              r_ready;
   logic              r_valid;
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_data;
   logic [PC_W-1:0]   r_skidPc;
   logic [DATA_W-1:0] r_skidData;
   logic              w_in;
   logic              w_out;

   assign w_in  = i_valid && r_ready;
   assign w_out = r_valid && i_ready;

   // Ready is a pure function of the next state, so it never depends on i_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= EMPTY;
         r_ready    <= 1'b1;
         r_valid    <= 1'b0;
         r_pc       <= RESET_PC;
         r_data     <= NOP_DATA;
         r_skidPc   <= RESET_PC;
         r_skidData <= NOP_DATA;
      end else if (flush) begin
         r_state <= EMPTY;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_pc    <= RESET_PC;
         r_data  <= NOP_DATA;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in) begin
                  r_pc    <= i_pc;
                  r_data  <= i_data;
                  r_valid <= 1'b1;
                  r_state <= FULL;
               end
            end
            FULL: begin
               if (w_in && !w_out) begin
                  r_skidPc   <= i_pc;
                  r_skidData <= i_data;
                  r_ready    <= 1'b0;
                  r_state    <= SKIDDED;
               end else if (w_out && !w_in) begin
                  r_valid <= 1'b0;
                  r_state <= EMPTY;
               end else if (w_in && w_out) begin
                  r_pc   <= i_pc;
                  r_data <= i_data;
               end
            end
            SKIDDED: begin
               if (w_out) begin
                  r_pc    <= r_skidPc;
                  r_data  <= r_skidData;
                  r_ready <= 1'b1;
                  r_state <= FULL;
               end
            end
            default: begin
               r_state <= EMPTY;
               r_ready <= 1'b1;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready = r_ready;
   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with optional skid
// buffer, flush-to-NOP and a saturating stall counter.
module pipe_stage_reg
   import cpu_pipe_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                PC_W     = 32,
   parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_PC_DEFAULT),
   parameter logic [DATA_W-1:0] NOP_DATA = '0,
   parameter int                SKID     = 1,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stage_reg_if.slave   bus
);

   logic              w_valid;
   logic              w_ready;
   logic [PC_W-1:0]   w_pc;
   logic [DATA_W-1:0] w_data;
   logic [CNT_W-1:0]  r_stallCnt;

   if (SKID != 0) begin : gSkid
      pipe_skid_buf #(
         .DATA_W   (DATA_W),
         .PC_W     (PC_W),
         .RESET_PC (RESET_PC),
         .NOP_DATA (NOP_DATA)
      ) u_skid (
         .clk     (clk),
         .rst     (rst),
         .flush   (bus.flush),
         .i_valid (bus.i_valid),
         .i_pc    (bus.i_pc),
         .i_data  (bus.i_data),
         .i_ready (bus.i_ready),
         .o_ready (w_ready),
         .o_valid (w_valid),
         .o_pc    (w_pc),
         .o_data  (w_data)
      );
   end else begin : gSingle
      logic              r_valid;
      logic [PC_W-1:0]   r_pc;
      logic [DATA_W-1:0] r_data;

      assign w_ready = !r_valid || bus.i_ready;

      // Single entry: a simultaneous in and out simply reloads the register.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_data  <= NOP_DATA;
         end else if (bus.flush) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_data  <= NOP_DATA;
         end else if (bus.i_valid && w_ready) begin
            r_valid <= 1'b1;
            r_pc    <= bus.i_pc;
            r_data  <= bus.i_data;
         end else if (r_valid && bus.i_ready) begin
            r_valid <= 1'b0;
         end
      end

      assign w_valid = r_valid;
      assign w_pc    = r_pc;
      assign w_data  = r_data;
   end

   // Stall cycles are counted up to all-ones and only reset clears them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCnt <= '0;
      end else if (w_valid && !bus.i_ready && !bus.flush && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
   end

   assign bus.o_valid     = w_valid;
   assign bus.o_ready     = w_ready;
   assign bus.o_pc        = w_pc;
   assign bus.o_data      = w_data;
   assign bus.o_stall_cnt = r_stallCnt;

endmodule
